// File: rtl/serial_pkg.sv
// Shared definitions for the outbound UART transmit path.
// Holds the transmitter state encoding and the 8N1 frame constants used by
// the byte FIFO and the serial_tx_port top level.
package serial_pkg;

  // Transmitter FSM states: line idle, start bit, data bits, stop bit
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // 8N1 framing: eight data bits, line rests high, start bit pulls it low
  localparam int   DATA_BITS  = 8;
  localparam int   BIT_CNT_W  = $clog2(DATA_BITS);
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/byte_fifo.sv
// Small circular byte FIFO buffering processor writes ahead of the UART.
// Ports:
//   clock  - system clock, rising edge
//   reset  - synchronous, active-low; empties the FIFO
//   push   - write din this edge (ignored when full)
//   pop    - drop the head entry this edge (ignored when empty)
//   din    - byte to store
//   dout   - current head entry (valid when not empty)
//   count  - occupancy, 0..DEPTH
//   full   - count == DEPTH
//   empty  - count == 0
module byte_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_BITS-1:0]   din,
  output logic [DATA_BITS-1:0]   dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q;
  logic [PW-1:0]        rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage array; it needs no reset because the pointers decide what is valid
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; a simultaneous
  // push and pop leaves the occupancy unchanged
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/serial_tx_port.sv
// Device-side endpoint of the processor's outbound serial writer port.
// Buffers written bytes and sends them as UART 8N1 frames, LSB first.
// Ports:
//   clock      - system clock, rising edge
//   reset      - synchronous, active-low; abandons any frame and flushes
//   wr_data    - byte from the processor
//   wr_en      - write strobe, accepted when ready_out is high
//   ready_out  - high while the FIFO has room
//   tx         - UART line, idles high
//   busy       - a frame is on the line or bytes are still queued
//   overflow   - sticky flag: a write arrived while ready_out was low
//   fifo_count - current FIFO occupancy
module serial_tx_port
  import serial_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             wr_data,
  input  logic                   wr_en,
  output logic                   ready_out,
  output logic                   tx,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]        BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(DATA_BITS - 1);

  tx_state_e            state_q;
  logic [BW-1:0]        baud_q;
  logic [BIT_CNT_W-1:0] bit_q;
  logic [7:0]           shift_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 overflow_q;

  logic [7:0]           fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push_en;
  logic                 pop_en;
  logic                 baud_done;
  logic [CW-1:0]        count_d;

  byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_en),
    .pop   (pop_en),
    .din   (wr_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ready_out = !fifo_full;
  assign push_en   = wr_en && ready_out;
  assign baud_done = (baud_q == BAUD_LAST);

  // The head is taken either from idle or exactly at the end of a stop bit,
  // which is what makes queued frames run back to back without a gap
  assign pop_en = !fifo_empty &&
                  ((state_q == IDLE) || ((state_q == STOP) && baud_done));

  // Occupancy after this edge, so busy can track state and count together
  always_comb begin
    count_d = fifo_count;
    if (push_en && !pop_en) begin
      count_d = fifo_count + 1'b1;
    end else if (!push_en && pop_en) begin
      count_d = fifo_count - 1'b1;
    end
  end

  // Transmit FSM with baud and bit counters; every output is registered.
  // busy defaults high and is only recomputed on the paths that land in IDLE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= LINE_IDLE;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en && !ready_out) begin
        overflow_q <= 1'b1;
      end
      busy_q <= 1'b1;
      case (state_q)
        IDLE: begin
          tx_q   <= LINE_IDLE;
          busy_q <= (count_d != '0);
          if (pop_en) begin
            shift_q <= fifo_dout;
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= START;
            tx_q    <= LINE_START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (baud_done) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_q == BIT_LAST) begin
              state_q <= STOP;
              tx_q    <= LINE_IDLE;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            if (pop_en) begin
              shift_q <= fifo_dout;
              bit_q   <= '0;
              state_q <= START;
              tx_q    <= LINE_START;
            end else begin
              state_q <= IDLE;
              busy_q  <= (count_d != '0);
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= LINE_IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_tx_port.sv
// Self-checking bench for serial_tx_port with DEPTH=4, CLKS_PER_BIT=4.
// A queue-and-timeline model predicts every output after every edge, and a
// line decoder turns tx back into bytes for comparison with what was sent.
module tb_serial_tx_port;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic                   clock;
  logic                   reset;
  logic [7:0]             wr_data;
  logic                   wr_en;
  logic                   ready_out;
  logic                   tx;
  logic                   busy;
  logic                   overflow;
  logic [$clog2(DEPTH):0] fifo_count;

  serial_tx_port #(
    .DEPTH(DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .ready_out  (ready_out),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model: queued bytes plus the edge at which the last frame began
  logic [7:0] mQ[$];
  logic [7:0] sentQ[$];
  logic [7:0] rxQ[$];
  logic [7:0] expQ[$];
  int         mEdge = 0;
  int         mLastPop = -1000;
  logic       mOvf = 1'b0;
  logic       mTx = 1'b1;
  logic       mBusy = 1'b0;
  logic [7:0] mCur = 8'h00;

  // Line decoder state
  bit         monInFrame = 1'b0;
  int         monPos = 0;
  logic [7:0] monByte = 8'h00;

  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       rstn;
    logic       tx;
    logic       busy;
    logic       ready;
    logic       ovf;
    int         count;
  } vec_t;

  vec_t       vecs[8];
  logic       pat[10];
  logic [7:0] wb[10];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h",
               name, mEdge, actual, expected);
    end
  endtask

  // One frame occupies FRAME edges starting at its pop edge; a new pop may
  // happen at any edge at least FRAME after the previous one
  task automatic modelEdge(input logic we, input logic [7:0] d, input logic rstn);
    int  off;
    int  k;
    bit  popNow;
    bit  ready;
    mEdge++;
    if (!rstn) begin
      mQ.delete();
      mLastPop = -1000;
      mOvf     = 1'b0;
      mTx      = 1'b1;
      mBusy    = 1'b0;
      return;
    end
    popNow = (mQ.size() > 0) && (mEdge >= mLastPop + FRAME);
    ready  = (mQ.size() != DEPTH);
    if (popNow) begin
      mCur = mQ.pop_front();
      sentQ.push_back(mCur);
      mLastPop = mEdge;
    end
    if (we) begin
      if (ready) mQ.push_back(d);
      else       mOvf = 1'b1;
    end
    off = mEdge - mLastPop;
    if (off < FRAME) begin
      k = off / CPB;
      if (k == 0)      mTx = 1'b0;
      else if (k == 9) mTx = 1'b1;
      else             mTx = mCur[k-1];
    end else begin
      mTx = 1'b1;
    end
    mBusy = (off < FRAME) || (mQ.size() != 0);
  endtask

  // Decodes frames from per-cycle tx samples, sampling mid-bit
  task automatic monitorStep(input bit rstApplied);
    int k;
    if (rstApplied) begin
      monInFrame = 1'b0;
      return;
    end
    if (!monInFrame) begin
      if (tx === 1'b0) begin
        monInFrame = 1'b1;
        monPos     = 0;
      end
    end else begin
      monPos++;
    end
    if (monInFrame) begin
      if ((monPos % CPB) == CPB / 2) begin
        k = monPos / CPB;
        if (k >= 1 && k <= 8) monByte[k-1] = tx;
        if (k == 9) begin
          checkOutput("stop_bit", tx, 1);
          rxQ.push_back(monByte);
        end
      end
      if (monPos == FRAME - 1) monInFrame = 1'b0;
    end
  endtask

  // Drive one edge's inputs, advance the model, then check after the edge
  task automatic applyStimulus(input logic we, input logic [7:0] d, input logic rstn);
    wr_en   = we;
    wr_data = d;
    reset   = rstn;
    modelEdge(we, d, rstn);
    @(negedge clock);
    monitorStep(!rstn);
    checkOutput("tx", tx, mTx);
    checkOutput("busy", busy, mBusy);
    checkOutput("ready_out", ready_out, mQ.size() != DEPTH);
    checkOutput("overflow", overflow, mOvf);
    checkOutput("fifo_count", fifo_count, mQ.size());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b1);
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  task automatic checkRx(input string name);
    checkOutput({name, "_len"}, rxQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++)
      checkOutput(name, rxQ[i], expQ[i]);
  endtask

  initial begin
    string s;
    int    idx;
    logic  we;

    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;

    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[1] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1};
    vecs[2] = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[3] = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2};
    vecs[4] = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3};
    vecs[5] = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4};
    vecs[6] = '{1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4};

    // Single 0x41 frame with its exact bit pattern
    $display("[TB] single byte 0x41");
    doReset(10);
    rxQ.delete();
    applyStimulus(1'b1, 8'h41, 1'b1);
    checkOutput("tx_before_fall", tx, 1);
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) begin
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("pattern_0x41", tx, pat[k]);
        checkOutput("busy_in_frame", busy, 1);
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("busy_after_frame", busy, 0);
    checkOutput("tx_idle_after_frame", tx, 1);
    expQ.delete();
    expQ.push_back(8'h41);
    checkRx("single_rx");

    // Back-to-back 'H','i' with no gap between frames
    $display("[TB] back-to-back Hi");
    rxQ.delete();
    applyStimulus(1'b1, 8'h48, 1'b1);
    applyStimulus(1'b1, 8'h69, 1'b1);
    for (int i = 1; i <= 85; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      if (i == 39) checkOutput("h_stop_bit", tx, 1);
      if (i == 40) checkOutput("i_start_no_gap", tx, 0);
      if (i == 79) checkOutput("busy_end_of_i", busy, 1);
      if (i == 80) checkOutput("busy_after_hi", busy, 0);
    end
    s = "";
    foreach (rxQ[i]) s = $sformatf("%s%c", s, rxQ[i]);
    $display("[TB] decoded: %s", s);
    expQ.delete();
    expQ.push_back(8'h48);
    expQ.push_back(8'h69);
    checkRx("hi_rx");

    // Full FIFO and sticky overflow, from the vector table
    $display("[TB] full and overflow");
    rxQ.delete();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].d, vecs[i].rstn);
      checkOutput("vec_tx", tx, vecs[i].tx);
      checkOutput("vec_busy", busy, vecs[i].busy);
      checkOutput("vec_ready", ready_out, vecs[i].ready);
      checkOutput("vec_overflow", overflow, vecs[i].ovf);
      checkOutput("vec_count", fifo_count, vecs[i].count);
    end
    idle(5 * FRAME);
    expQ.delete();
    for (int i = 1; i <= 5; i++) expQ.push_back(8'(i));
    checkRx("overflow_rx");
    checkOutput("overflow_sticky", overflow, 1);

    // Ten bytes written only while there is room: pointers wrap twice
    $display("[TB] wrap-around");
    doReset(2);
    rxQ.delete();
    expQ.delete();
    for (int i = 0; i < 10; i++) begin
      wb[i] = 8'($urandom);
      expQ.push_back(wb[i]);
    end
    idx = 0;
    for (int cyc = 0; cyc < 12 * FRAME; cyc++) begin
      if (idx < 10 && mQ.size() != DEPTH) begin
        applyStimulus(1'b1, wb[idx], 1'b1);
        idx++;
      end else begin
        applyStimulus(1'b0, 8'h00, 1'b1);
      end
    end
    checkOutput("wrap_all_written", idx, 10);
    checkRx("wrap_rx");
    checkOutput("wrap_no_overflow", overflow, 0);

    // Random write traffic, including writes into a full FIFO
    $display("[TB] random traffic");
    doReset(2);
    rxQ.delete();
    sentQ.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      we = ($urandom_range(0, 2) == 0);
      applyStimulus(we, 8'($urandom), 1'b1);
    end
    idle(FRAME * (DEPTH + 2));
    expQ = sentQ;
    checkRx("random_rx");

    // Reset during data bit 3 of a 0x55 frame with two bytes queued
    $display("[TB] reset mid-frame");
    doReset(2);
    rxQ.delete();
    applyStimulus(1'b1, 8'h55, 1'b1);
    applyStimulus(1'b1, 8'hAA, 1'b1);
    applyStimulus(1'b1, 8'h33, 1'b1);
    idle(15);
    checkOutput("queued_before_reset", fifo_count, 2);
    checkOutput("data_bit3_of_0x55", tx, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_count", fifo_count, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", ready_out, 1);
    idle(3 * FRAME);
    checkOutput("no_frames_after_reset", rxQ.size(), 0);
    checkOutput("line_idle_after_reset", tx, 1);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
